fetch_ctrl: RTL and testbench

- Sequencing controller for the fetch stage: owns the PC and EPC and drives a multi-cycle instruction memory with a level Rd/Done handshake.
- Resolves redirects (exception, RTI, branch/jump) and halt, and absorbs back-pressure from decode with a 1-entry skid buffer.
- Generates the load/stall/flush controls for the F/D pipe register. Sits between imem and the F/D register; fetch_stage datapath instances consume its Addr/Instr/IncPC.

---
 rtl/fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_skid_buf.sv | 40 ++++
 rtl/fetch_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StDrain  = 2'b01,
    StHalted = 2'b10
  } fetch_state_e;

  localparam logic [15:0] PC_INCR            = 16'd2;
  localparam logic [15:0] RESET_PC_DEFAULT   = 16'h0000;
  localparam logic [15:0] EXC_VECTOR_DEFAULT = 16'h0002;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its return address.
module fetch_skid_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        capture_i,
  input  logic        release_i,
  input  logic        clear_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] inc_pc_i,
  output logic        valid_o,
  output logic [15:0] instr_o,
  output logic [15:0] inc_pc_o
);

  logic        valid_q;
  logic [15:0] instr_q;
  logic [15:0] inc_pc_q;

  // Clear wins over capture so a redirect never leaves stale data behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      instr_q  <= 16'h0000;
      inc_pc_q <= 16'h0000;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (capture_i) begin
      valid_q  <= 1'b1;
      instr_q  <= instr_i;
      inc_pc_q <= inc_pc_i;
    end else if (release_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign instr_o  = instr_q;
  assign inc_pc_o = inc_pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: PC/EPC, imem handshake, redirects, halt, F/D control.
// Define FETCH_CTRL_PERF_EN to add the BubbleCnt/RedirectCnt performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] BranchPC,
  input  logic        BranchJumpTaken,
  input  logic        Exception,
  input  logic        Rti,
  input  logic        Halt,
  input  logic        Stall,
  input  logic        MemDone,
  input  logic [15:0] MemInstr,
  output logic [15:0] Addr,
  output logic        MemRd,
  output logic [15:0] Instr,
  output logic [15:0] IncPC,
  output logic        FdStall,
  output logic        FdFlush,
  output logic        Halted,
  output logic [15:0] Epc
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0] BubbleCnt,
  output logic [15:0] RedirectCnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  epc_q, epc_d;
  logic [15:0]  pc_inc;
  logic [15:0]  target;
  logic         redirect;

  logic         skid_valid, skid_cap, skid_rel, skid_clr;
  logic [15:0]  skid_instr, skid_inc_pc;

  logic         mem_rd, fd_stall, fd_flush;
  logic [15:0]  instr, inc_pc;

  assign pc_inc   = pc_q + PC_INCR;
  assign redirect = Exception | Rti | BranchJumpTaken;
  assign target   = Exception ? EXC_VECTOR : (Rti ? epc_q : BranchPC);

  fetch_skid_buf u_skid (
    .clk_i     (clk),
    .rst_i     (rst),
    .capture_i (skid_cap),
    .release_i (skid_rel),
    .clear_i   (skid_clr),
    .instr_i   (MemInstr),
    .inc_pc_i  (pc_inc),
    .valid_o   (skid_valid),
    .instr_o   (skid_instr),
    .inc_pc_o  (skid_inc_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      epc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    mem_rd   = 1'b0;
    fd_stall = 1'b0;
    fd_flush = 1'b0;
    instr    = 16'h0000;
    inc_pc   = 16'h0000;
    skid_cap = 1'b0;
    skid_rel = 1'b0;
    skid_clr = 1'b0;

    unique case (state_q)
      StRun: begin
        mem_rd = ~skid_valid;
        if (redirect) begin
          fd_flush = 1'b1;
          skid_clr = 1'b1;
          pc_d     = target;
          if (Exception) epc_d = pc_q;
          // A request still in flight must complete before a new one issues.
          if (mem_rd && !MemDone) state_d = StDrain;
        end else if (Halt) begin
          fd_flush = 1'b1;
          skid_clr = 1'b1;
          state_d  = StHalted;
        end else if (!skid_valid) begin
          if (MemDone) begin
            pc_d = pc_inc;
            if (Stall) begin
              fd_stall = 1'b1;
              skid_cap = 1'b1;
            end else begin
              instr  = MemInstr;
              inc_pc = pc_inc;
            end
          end else if (Stall) begin
            fd_stall = 1'b1;
          end else begin
            fd_flush = 1'b1;
          end
        end else if (Stall) begin
          fd_stall = 1'b1;
        end else begin
          instr    = skid_instr;
          inc_pc   = skid_inc_pc;
          skid_rel = 1'b1;
        end
      end

      StDrain: begin
        fd_flush = 1'b1;
        if (redirect) begin
          pc_d = target;
          if (Exception) epc_d = pc_q;
        end
        if (Halt && !redirect) begin
          state_d = StHalted;
        end else if (MemDone) begin
          state_d = StRun;
        end
      end

      StHalted: begin
        fd_flush = 1'b1;
      end

      default: begin
        fd_flush = 1'b1;
        state_d  = StRun;
      end
    endcase
  end

  // Outputs are forced to their reset values while rst is asserted.
  assign Addr    = pc_q;
  assign MemRd   = mem_rd & ~rst;
  assign FdFlush = fd_flush | rst;
  assign FdStall = fd_stall & ~fd_flush & ~rst;
  assign Instr   = rst ? 16'h0000 : instr;
  assign IncPC   = rst ? 16'h0000 : inc_pc;
  assign Halted  = (state_q == StHalted) & ~rst;
  assign Epc     = epc_q;

`ifdef FETCH_CTRL_PERF_EN
  logic        bubble, redirect_acc;
  logic [15:0] bubble_cnt_q, redirect_cnt_q;

  assign redirect_acc = redirect & (state_q != StHalted);
  assign bubble = (state_q == StDrain) |
                  ((state_q == StRun) & ~skid_valid & ~redirect & ~Halt & ~MemDone & ~Stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q   <= 16'h0000;
      redirect_cnt_q <= 16'h0000;
    end else begin
      if (bubble) bubble_cnt_q <= sat_inc(bubble_cnt_q);
      if (redirect_acc) redirect_cnt_q <= sat_inc(redirect_cnt_q);
    end
  end

  assign BubbleCnt   = bubble_cnt_q;
  assign RedirectCnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios, then randomized traffic vs a reference model.
module tb_fetch_ctrl;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] EXC_PC = 16'h0002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] BranchPC = '0;
  logic        BranchJumpTaken = 1'b0;
  logic        Exception = 1'b0;
  logic        Rti = 1'b0;
  logic        Halt = 1'b0;
  logic        Stall = 1'b0;
  logic        MemDone = 1'b0;
  logic [15:0] MemInstr = '0;
  logic [15:0] Addr, Instr, IncPC, Epc;
  logic        MemRd, FdStall, FdFlush, Halted;

  fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .BranchPC        (BranchPC),
    .BranchJumpTaken (BranchJumpTaken),
    .Exception       (Exception),
    .Rti             (Rti),
    .Halt            (Halt),
    .Stall           (Stall),
    .MemDone         (MemDone),
    .MemInstr        (MemInstr),
    .Addr            (Addr),
    .MemRd           (MemRd),
    .Instr           (Instr),
    .IncPC           (IncPC),
    .FdStall         (FdStall),
    .FdFlush         (FdFlush),
    .Halted          (Halted),
    .Epc             (Epc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural view of the fetch unit.
  logic [15:0] m_pc, m_epc, m_sk_instr, m_sk_inc;
  bit          m_sk_v, m_drain, m_halt;

  task automatic model_reset();
    m_pc = RST_PC; m_epc = '0; m_sk_instr = '0; m_sk_inc = '0;
    m_sk_v = 0; m_drain = 0; m_halt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {BranchJumpTaken, Exception, Rti, Halt, Stall, MemDone} = '0;
    #1;
    check_eq("rst_memrd", 16'(MemRd), 16'd0);
    check_eq("rst_flush", 16'(FdFlush), 16'd1);
    check_eq("rst_stall", 16'(FdStall), 16'd0);
    check_eq("rst_halted", 16'(Halted), 16'd0);
    check_eq("rst_instr", Instr, 16'h0000);
    check_eq("rst_incpc", IncPC, 16'h0000);
    check_eq("rst_epc", Epc, 16'h0000);
    check_eq("rst_addr", Addr, RST_PC);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit done, input logic [15:0] mi, input bit stall, input bit bj,
                      input logic [15:0] bpc, input bit exc, input bit rti, input bit halt);
    bit          e_rd, e_flush, e_stall, deliver, redir;
    logic [15:0] e_instr, e_inc, tgt;
    MemDone = done; MemInstr = mi; Stall = stall; BranchJumpTaken = bj;
    BranchPC = bpc; Exception = exc; Rti = rti; Halt = halt;
    #3;
    e_rd = 0; e_flush = 0; e_stall = 0; deliver = 0; e_instr = '0; e_inc = '0;
    redir = exc | rti | bj;
    tgt = exc ? EXC_PC : (rti ? m_epc : bpc);
    check_eq("addr", Addr, m_pc);
    check_eq("epc", Epc, m_epc);
    check_eq("halted", 16'(Halted), 16'(m_halt));
    if (m_halt) begin
      e_flush = 1;
    end else if (m_drain) begin
      e_flush = 1;
      if (redir) begin
        if (exc) m_epc = m_pc;
        m_pc = tgt;
      end
      if (halt && !redir) begin m_halt = 1; m_drain = 0; end
      else if (done) m_drain = 0;
    end else begin
      e_rd = !m_sk_v;
      if (redir) begin
        e_flush = 1;
        if (exc) m_epc = m_pc;
        m_drain = !m_sk_v && !done;
        m_sk_v = 0;
        m_pc = tgt;
      end else if (halt) begin
        e_flush = 1; m_halt = 1; m_sk_v = 0;
      end else if (!m_sk_v) begin
        if (done && !stall) begin
          deliver = 1; e_instr = mi; e_inc = m_pc + 16'd2; m_pc = m_pc + 16'd2;
        end else if (done) begin
          e_stall = 1; m_sk_v = 1; m_sk_instr = mi; m_sk_inc = m_pc + 16'd2;
          m_pc = m_pc + 16'd2;
        end else if (stall) e_stall = 1;
        else e_flush = 1;
      end else if (stall) begin
        e_stall = 1;
      end else begin
        deliver = 1; e_instr = m_sk_instr; e_inc = m_sk_inc; m_sk_v = 0;
      end
    end
    check_eq("memrd", 16'(MemRd), 16'(e_rd));
    check_eq("fdflush", 16'(FdFlush), 16'(e_flush));
    check_eq("fdstall", 16'(FdStall), 16'(e_stall));
    if (deliver) begin
      check_eq("instr", Instr, e_instr);
      check_eq("incpc", IncPC, e_inc);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_step(input bit done, input logic [15:0] mi);
    step(done, mi, 0, 0, 16'h0, 0, 0, 0);
  endtask

  initial begin
    int halted_cycles;
    bit busy;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Zero-wait fetches, then a 3-cycle wait at PC=4.
    run_step(1, 16'hA000);
    run_step(1, 16'hA001);
    for (int i = 0; i < 3; i++) run_step(0, 16'hDEAD);
    check_eq("addr_held", Addr, 16'h0004);
    run_step(1, 16'hB000);
    run_step(1, 16'hB001);
    // Skid capture at PC=8, release when Stall drops.
    step(1, 16'h1234, 1, 0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 1, 0, 16'h0, 0, 0, 0);
    check_eq("skid_memrd", 16'(MemRd), 16'd0);
    step(0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
    // Branch with a request outstanding: drain, discard late data.
    step(0, 16'h0, 0, 1, 16'h0040, 0, 0, 0);
    run_step(1, 16'hBAD0);
    check_eq("branch_addr", Addr, 16'h0040);
    step(1, 16'h0, 0, 1, 16'h0010, 0, 0, 0);
    step(1, 16'h0, 0, 0, 16'h0, 1, 0, 0);
    check_eq("exc_epc", Epc, 16'h0010);
    check_eq("exc_addr", Addr, EXC_PC);
    run_step(1, 16'hC000);
    step(1, 16'h0, 0, 0, 16'h0, 0, 1, 0);
    check_eq("rti_addr", Addr, 16'h0010);
    step(1, 16'h0, 0, 0, 16'h0, 1, 1, 0);
    check_eq("exc_over_rti", Addr, EXC_PC);
    // PC wrap at 16'hFFFE.
    step(1, 16'h0, 0, 1, 16'hFFFE, 0, 0, 0);
    run_step(1, 16'h5555);
    check_eq("wrap_addr", Addr, 16'h0000);
    // Halt with a branch: branch wins; then async reset mid-drain.
    step(0, 16'h0, 0, 1, 16'h0020, 0, 0, 1);
    check_eq("halt_vs_branch", 16'(Halted), 16'd0);
    do_reset();
    run_step(1, 16'h7000);
    step(0, 16'h0, 0, 0, 16'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 1, 16'h0080, 0, 0, 0);
    do_reset();

    // Randomized traffic.
    halted_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      busy = m_drain || (!m_halt && !m_sk_v);
      step(busy && ($urandom_range(9) < 6), 16'($urandom()), $urandom_range(9) < 3,
           $urandom_range(99) < 8, 16'($urandom()), $urandom_range(99) < 3,
           $urandom_range(99) < 3, $urandom_range(199) == 0);
      if (m_halt) halted_cycles++;
      if (halted_cycles > 4) begin
        halted_cycles = 0;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
